block_code_encoder: RTL
=======================

Name: block_code_encoder

Overview:
- Transmit-side counterpart of the block-code decoder (top_block_code).
- Takes info bits on an AXI4-Stream slave, one bit per beat, and spreads each bit into code_length signed chips. Barker-5 and Barker-13 codes are supported.
- Emits chips on an AXI4-Stream master as signed DATA_WIDTH soft symbols, in the format the decoder consumes.
- Frames are delimited by tlast and nominally carry NUM_SYMBOLS info bits.

Parameters:
- DATA_WIDTH, 4: width of an output chip, signed two's complement.
- NUM_SYMBOLS, 20: nominal info bits per frame. Only used by the frame check.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- s_axis_aresetn  in  1  reset, asynchronous assert, active-low.
- code_length  in  8  code selector, 5 or 13. Sampled only at frame start.
- s_axis_tdata  in  8  bit 0 is the info bit; bits 7:1 are ignored.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last info bit of the frame.
- m_axis_tdata  out  DATA_WIDTH  chip value, ±AMP with AMP = 2^(DATA_WIDTH-1)-1.
- m_axis_tvalid  out  1  chip valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last chip of the last bit of the frame.
- code_err  out  1  sticky flag: unsupported code_length was sampled.
- frame_err  out  1  one-cycle pulse on a frame-length mismatch (see Optional Feature).

Behaviour:
- Reset values: s_axis_tready=0 while reset is asserted, then 1 on the first clock after release. m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, code_err=0, frame_err=0. FSM goes to IDLE; chip counter, frame-start flag (1) and bit counter are cleared.
- Codes, MSB chip first: Barker-5 = 11101; Barker-13 = 1111100110101.
- Chip mapping:
  - info bit 1: code bit 1 -> +AMP, code bit 0 -> -AMP.
  - info bit 0: inverted sequence.
  - With DATA_WIDTH=4: +7 = 4'h7, -7 = 4'h9.
- Code latch: code_length is latched on the handshake of the first bit of a frame (first after reset or after a beat with s_axis_tlast). It is held for the whole frame.
  - Value 5 selects Barker-5. Value 13 selects Barker-13.
  - Any other value selects Barker-13 and sets code_err, which stays set until reset.
- FSM states:
  - IDLE: s_axis_tready=1, m_axis_tvalid=0. On s_axis_tvalid&&s_axis_tready, latch the bit, its tlast and (at frame start) the code, load chip 0, go to SEND. Latency: input handshake at cycle N gives the first chip valid at N+1.
  - SEND: m_axis_tvalid=1. The chip counter advances only on an m_axis handshake; tdata/tlast are stable while m_axis_tready=0.
    - s_axis_tready = (chip_idx==L-1) && m_axis_tready, combinational.
    - On the last-chip handshake with an input beat available: load the next bit and stay in SEND. This gives back-to-back chips with no bubble.
    - On the last-chip handshake with no input beat: go to IDLE.
- m_axis_tlast is 1 only on chip L-1 of a bit whose latched s_axis_tlast was 1. The next beat then starts a new frame: code is re-latched and the bit counter is cleared.
- Throughput: 1 chip/cycle when m_axis_tready=1, i.e. one info bit per L cycles.
- Simultaneous s_axis tlast and code change: the new code applies from the next frame only.
- Reset mid-frame: outputs clear asynchronously and any partial symbol is discarded. The next beat after release is a frame start.

Optional Feature:
- Macro: BLOCK_CODE_ENC_FRAME_CHECK_EN.
- Defined:
  - An 8-bit counter counts accepted bits per frame, saturating at 255.
  - On acceptance of a beat with s_axis_tlast: if count+1 != NUM_SYMBOLS, frame_err pulses high for one cycle.
  - The data path is unaffected.
- Not defined: no counter is built and frame_err is tied to 0.

Test Plan:
- Reset released, code_length=5, a single bit 1 with tlast, m_axis_tready=1 -> chips 7,7,7,9,7 on 5 consecutive cycles; m_axis_tlast on the 5th chip only; first chip one cycle after the input handshake.
- code_length=13, 20 bits alternating 1,0, tlast on bit 20, tready=1 -> 260 gap-free chips. Bit 0 produces 7,7,7,7,7,9,9,7,7,9,7,9,7 and bit 1 its inverse. Single tlast at chip 260. frame_err=0 with the macro defined.
- Random m_axis_tready gaps (≈50%) during the Barker-13 frame -> identical chip sequence to the gap-free run; tdata/tlast held while stalled; s_axis_tready high only on the last-chip handshake or in IDLE.
- code_length changed 13->5 mid-frame, then a new frame -> current frame stays Barker-13; the next frame uses Barker-5. code_length=6 at a frame start -> Barker-13 used and code_err=1 until reset.
- Macro defined, a frame of 19 bits -> frame_err pulses for exactly one cycle at the tlast input handshake. A frame of 20 bits -> no pulse.
- Reset asserted at chip 6 of bit 3 -> m_axis_tvalid drops asynchronously. After release, a new frame with code_length=5 starts cleanly at chip 0 with no residual chips.

Source files
------------

// File: rtl/block_code_encoder.sv
// -----------------------------------------------------------------------------
// block_code_encoder
//
// Transmit-side Barker spreader. Each info bit accepted on the AXI4-Stream
// slave is expanded into L signed chips (L = 5 or 13) on the AXI4-Stream
// master. Chips are +AMP / -AMP with AMP = 2^(DATA_WIDTH-1)-1. An info bit of
// 1 sends the code as-is (code bit 1 -> +AMP); an info bit of 0 sends it
// inverted. Chips go out MSB of the code first.
//
// Optional feature macro: BLOCK_CODE_ENC_FRAME_CHECK_EN
//   defined   : per-frame accepted-bit counter; frame_err pulses for one cycle
//               (the cycle after the tlast input handshake) when the frame did
//               not carry NUM_SYMBOLS bits.
//   undefined : no counter, frame_err tied low.
//
// Ports:
//   clk             clock, rising edge
//   s_axis_aresetn  asynchronous active-low reset
//   code_length     code selector (5 or 13), latched at frame start
//   s_axis_tdata    bit 0 = info bit, bits 7:1 ignored
//   s_axis_tvalid   input valid
//   s_axis_tready   input ready
//   s_axis_tlast    last info bit of the frame
//   m_axis_tdata    chip value, signed DATA_WIDTH
//   m_axis_tvalid   chip valid
//   m_axis_tready   downstream ready
//   m_axis_tlast    last chip of the last bit of the frame
//   code_err        sticky: unsupported code_length was latched
//   frame_err       one-cycle pulse on frame-length mismatch
// -----------------------------------------------------------------------------
module block_code_encoder #(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_SYMBOLS = 20
) (
    input  logic                  clk,
    input  logic                  s_axis_aresetn,
    input  logic [7:0]            code_length,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  code_err,
    output logic                  frame_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] AMP_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] AMP_NEG  = ~AMP_POS + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [12:0]           BARKER13 = 13'b1111100110101;
    localparam logic [4:0]            BARKER5  = 5'b11101;

    // Chip value for chip idx of the selected code, spread by the info bit.
    function automatic logic [DATA_WIDTH-1:0] chip_value(
        input logic       use13,
        input logic [3:0] idx,
        input logic       info
    );
        logic code_bit;
        code_bit = 1'b0;
        if (use13) begin
            code_bit = BARKER13[4'd12 - idx];
        end else begin
            code_bit = BARKER5[3'(4'd4 - idx)];
        end
        return (code_bit == info) ? AMP_POS : AMP_NEG;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [3:0]              chip_idx_r, chip_idx_nxt_s;
    logic                    info_bit_r, info_bit_nxt_s;
    logic                    bit_last_r, bit_last_nxt_s;
    logic                    use13_r, use13_nxt_s;
    logic                    frame_start_r, frame_start_nxt_s;
    logic                    code_err_r, code_err_nxt_s;
    logic                    ready_en_r;
    logic [DATA_WIDTH-1:0]   m_tdata_r, m_tdata_nxt_s;
    logic                    m_tvalid_r, m_tvalid_nxt_s;
    logic                    m_tlast_r, m_tlast_nxt_s;

    logic [3:0]              last_idx_s;
    logic                    last_chip_s;
    logic                    out_fire_s;
    logic                    s_ready_s;
    logic                    in_fire_s;
    logic                    code_ok_s;
    logic                    load_use13_s;
    logic [3:0]              idx_inc_s;
    logic                    unused_tdata_s;

    assign unused_tdata_s = ^s_axis_tdata[7:1];

    // Handshake qualifiers and code selection for the beat being loaded.
    always_comb begin
        last_idx_s   = use13_r ? 4'd12 : 4'd4;
        last_chip_s  = (chip_idx_r == last_idx_s);
        idx_inc_s    = chip_idx_r + 4'd1;
        out_fire_s   = m_tvalid_r && m_axis_tready;
        // In SEND the next bit can only enter on the last-chip handshake, so
        // consecutive bits run back to back without a bubble.
        if (state_r == IDLE) begin
            s_ready_s = ready_en_r;
        end else begin
            s_ready_s = ready_en_r && last_chip_s && m_axis_tready;
        end
        in_fire_s    = s_axis_tvalid && s_ready_s;
        code_ok_s    = (code_length == 8'd5) || (code_length == 8'd13);
        // Anything other than 5 falls back to Barker-13.
        if (frame_start_r) begin
            load_use13_s = (code_length != 8'd5);
        end else begin
            load_use13_s = use13_r;
        end
    end

    // Next-state, chip counter and registered-output next values.
    always_comb begin
        state_nxt_s    = state_r;
        chip_idx_nxt_s = chip_idx_r;
        info_bit_nxt_s = info_bit_r;
        bit_last_nxt_s = bit_last_r;
        use13_nxt_s    = use13_r;
        m_tdata_nxt_s  = m_tdata_r;
        m_tvalid_nxt_s = m_tvalid_r;
        m_tlast_nxt_s  = m_tlast_r;

        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    state_nxt_s    = SEND;
                    chip_idx_nxt_s = 4'd0;
                    info_bit_nxt_s = s_axis_tdata[0];
                    bit_last_nxt_s = s_axis_tlast;
                    use13_nxt_s    = load_use13_s;
                    m_tdata_nxt_s  = chip_value(load_use13_s, 4'd0, s_axis_tdata[0]);
                    m_tvalid_nxt_s = 1'b1;
                    m_tlast_nxt_s  = 1'b0;
                end else begin
                    m_tvalid_nxt_s = 1'b0;
                    m_tlast_nxt_s  = 1'b0;
                end
            end
            SEND: begin
                if (out_fire_s) begin
                    if (last_chip_s) begin
                        if (in_fire_s) begin
                            chip_idx_nxt_s = 4'd0;
                            info_bit_nxt_s = s_axis_tdata[0];
                            bit_last_nxt_s = s_axis_tlast;
                            use13_nxt_s    = load_use13_s;
                            m_tdata_nxt_s  = chip_value(load_use13_s, 4'd0, s_axis_tdata[0]);
                            m_tvalid_nxt_s = 1'b1;
                            m_tlast_nxt_s  = 1'b0;
                        end else begin
                            state_nxt_s    = IDLE;
                            chip_idx_nxt_s = 4'd0;
                            m_tdata_nxt_s  = {DATA_WIDTH{1'b0}};
                            m_tvalid_nxt_s = 1'b0;
                            m_tlast_nxt_s  = 1'b0;
                        end
                    end else begin
                        chip_idx_nxt_s = idx_inc_s;
                        m_tdata_nxt_s  = chip_value(use13_r, idx_inc_s, info_bit_r);
                        m_tlast_nxt_s  = bit_last_r && (idx_inc_s == last_idx_s);
                    end
                end else begin
                    // Stalled: hold the presented chip.
                    m_tvalid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                m_tvalid_nxt_s = 1'b0;
                m_tlast_nxt_s  = 1'b0;
            end
        endcase

        if (in_fire_s) begin
            frame_start_nxt_s = s_axis_tlast;
        end else begin
            frame_start_nxt_s = frame_start_r;
        end
        code_err_nxt_s = code_err_r | (in_fire_s && frame_start_r && !code_ok_s);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_r       <= IDLE;
            chip_idx_r    <= 4'd0;
            info_bit_r    <= 1'b0;
            bit_last_r    <= 1'b0;
            use13_r       <= 1'b0;
            frame_start_r <= 1'b1;
            code_err_r    <= 1'b0;
            ready_en_r    <= 1'b0;
            m_tdata_r     <= {DATA_WIDTH{1'b0}};
            m_tvalid_r    <= 1'b0;
            m_tlast_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            chip_idx_r    <= chip_idx_nxt_s;
            info_bit_r    <= info_bit_nxt_s;
            bit_last_r    <= bit_last_nxt_s;
            use13_r       <= use13_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            code_err_r    <= code_err_nxt_s;
            ready_en_r    <= 1'b1;
            m_tdata_r     <= m_tdata_nxt_s;
            m_tvalid_r    <= m_tvalid_nxt_s;
            m_tlast_r     <= m_tlast_nxt_s;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tlast  = m_tlast_r;
    assign code_err      = code_err_r;

`ifdef BLOCK_CODE_ENC_FRAME_CHECK_EN
    logic [7:0] bit_cnt_r;
    logic       frame_err_r;
    logic [7:0] cnt_base_s;
    logic [8:0] cnt_inc_s;

    // Bits already accepted in this frame, zero at a frame start.
    always_comb begin
        if (frame_start_r) begin
            cnt_base_s = 8'd0;
        end else begin
            cnt_base_s = bit_cnt_r;
        end
        cnt_inc_s = {1'b0, cnt_base_s} + 9'd1;
    end

    // Saturating bit counter and frame-length mismatch pulse.
    always_ff @(posedge clk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            bit_cnt_r   <= 8'd0;
            frame_err_r <= 1'b0;
        end else if (in_fire_s) begin
            bit_cnt_r   <= (cnt_base_s == 8'hFF) ? 8'hFF : cnt_inc_s[7:0];
            frame_err_r <= s_axis_tlast && (cnt_inc_s != 9'(NUM_SYMBOLS));
        end else begin
            frame_err_r <= 1'b0;
        end
    end

    assign frame_err = frame_err_r;
`else
    logic [7:0] unused_num_symbols_s;
    assign unused_num_symbols_s = 8'(NUM_SYMBOLS);
    assign frame_err = 1'b0;
`endif

endmodule
